// File: rtl/logic_combiner_n_if.sv
// Register-style write/read bus for logic_combiner_n.
interface logic_combiner_n_if #(
  parameter int W = 8
);
  logic [3:0]   write_address;
  logic [W-1:0] write_data;
  logic         write_en;
  logic         write_rdy;
  logic [3:0]   read_address;
  logic         read_en;
  logic [W-1:0] read_data;
  logic         read_rdy;

  modport master (
    output write_address, write_data, write_en, read_address, read_en,
    input  write_rdy, read_data, read_rdy
  );

  modport slave (
    input  write_address, write_data, write_en, read_address, read_en,
    output write_rdy, read_data, read_rdy
  );
endinterface

// File: rtl/logic_combiner_n.sv
// N-channel logic combiner: per-channel input FIFOs are popped together and
// reduced (OR/AND/XOR/channel-0) into an output FIFO read through a register map.
module logic_combiner_n #(
  parameter int NCH       = 2,
  parameter int W         = 8,
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  logic_combiner_n_if.slave bus
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = OAW + 1;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_CH0 = 2'd3
  } mode_t;

  logic [W-1:0]   in_mem_q  [NCH][IN_DEPTH];
  logic [IAW-1:0] in_rd_q   [NCH];
  logic [IAW-1:0] in_rd_d   [NCH];
  logic [IAW-1:0] in_wr_q   [NCH];
  logic [IAW-1:0] in_wr_d   [NCH];
  logic [ICW-1:0] in_cnt_q  [NCH];
  logic [ICW-1:0] in_cnt_d  [NCH];

  logic [W-1:0]   out_mem_q [OUT_DEPTH];
  logic [OAW-1:0] out_rd_q, out_rd_d;
  logic [OAW-1:0] out_wr_q, out_wr_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;

  mode_t          mode_q, mode_d;
  logic [7:0]     drop_q, drop_d;

  logic [NCH-1:0] in_full, in_empty, push_in;
  logic           clr, drop, fire, pop_out, out_full, out_empty;
  logic [W-1:0]   result, out_head;

  assign bus.write_rdy = 1'b1;
  assign bus.read_rdy  = 1'b1;

  // Decode strobes; all flags are taken from pre-edge state.
  always_comb begin
    clr      = bus.write_en && (bus.write_address == 4'd13);
    in_full  = '0;
    in_empty = '0;
    push_in  = '0;
    drop     = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      in_full[i]  = (in_cnt_q[i] == ICW'(IN_DEPTH));
      in_empty[i] = (in_cnt_q[i] == '0);
      if (bus.write_en && (bus.write_address == 4'(i))) begin
        if (in_full[i]) drop = 1'b1;
        else            push_in[i] = 1'b1;
      end
    end
    out_full  = (out_cnt_q == OCW'(OUT_DEPTH));
    out_empty = (out_cnt_q == '0);
    fire      = !(|in_empty) && !out_full && !clr;
    pop_out   = bus.read_en && (bus.read_address == 4'd9) && !out_empty && !clr;
    out_head  = out_empty ? '0 : out_mem_q[out_rd_q];
  end

  // Reduce the current channel heads according to the registered mode.
  always_comb begin
    logic [W-1:0] or_acc, and_acc, xor_acc;
    or_acc  = '0;
    and_acc = '1;
    xor_acc = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      or_acc  = or_acc  | in_mem_q[i][in_rd_q[i]];
      and_acc = and_acc & in_mem_q[i][in_rd_q[i]];
      xor_acc = xor_acc ^ in_mem_q[i][in_rd_q[i]];
    end
    case (mode_q)
      MODE_OR:  result = or_acc;
      MODE_AND: result = and_acc;
      MODE_XOR: result = xor_acc;
      default:  result = in_mem_q[0][in_rd_q[0]];
    endcase
  end

  // Next-state for pointers, occupancies, mode and drop counter.
  always_comb begin
    in_rd_d   = in_rd_q;
    in_wr_d   = in_wr_q;
    in_cnt_d  = in_cnt_q;
    out_rd_d  = out_rd_q;
    out_wr_d  = out_wr_q;
    out_cnt_d = out_cnt_q;
    mode_d    = mode_q;
    drop_d    = drop_q;
    if (clr) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        in_rd_d[i]  = '0;
        in_wr_d[i]  = '0;
        in_cnt_d[i] = '0;
      end
      out_rd_d  = '0;
      out_wr_d  = '0;
      out_cnt_d = '0;
      drop_d    = '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        in_rd_d[i]  = in_rd_q[i] + IAW'(fire);
        in_wr_d[i]  = in_wr_q[i] + IAW'(push_in[i]);
        in_cnt_d[i] = in_cnt_q[i] + ICW'(push_in[i]) - ICW'(fire);
      end
      out_rd_d  = out_rd_q + OAW'(pop_out);
      out_wr_d  = out_wr_q + OAW'(fire);
      out_cnt_d = out_cnt_q + OCW'(fire) - OCW'(pop_out);
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      if (bus.write_en && (bus.write_address == 4'd12)) mode_d = mode_t'(bus.write_data[1:0]);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        in_rd_q[i]  <= '0;
        in_wr_q[i]  <= '0;
        in_cnt_q[i] <= '0;
      end
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_cnt_q <= '0;
      mode_q    <= MODE_OR;
      drop_q    <= '0;
    end else begin
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      in_cnt_q  <= in_cnt_d;
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      out_cnt_q <= out_cnt_d;
      mode_q    <= mode_d;
      drop_q    <= drop_d;
    end
  end

  // FIFO storage; contents are only meaningful through the occupancy counters.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (push_in[i]) in_mem_q[i][in_wr_q[i]] <= bus.write_data;
    end
    if (fire) out_mem_q[out_wr_q] <= result;
  end

  // Combinational register read mux.
  always_comb begin
    bus.read_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.read_address == 4'(i)) bus.read_data = W'(!in_full[i]);
    end
    case (bus.read_address)
      4'd8:    bus.read_data = W'(!out_empty);
      4'd9:    bus.read_data = out_head;
      4'd10:   bus.read_data = W'(mode_q);
      4'd11:   bus.read_data = W'(drop_q);
      4'd12:   bus.read_data = W'(out_cnt_q);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_logic_combiner_n.sv
// Self-checking bench for logic_combiner_n with a queue-based reference model.
module tb_logic_combiner_n;

  localparam int NCH       = 2;
  localparam int W         = 8;
  localparam int IN_DEPTH  = 2;
  localparam int OUT_DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic_combiner_n_if #(.W(W)) bus();

  logic_combiner_n #(
    .NCH(NCH), .W(W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #20 CLK = ~CLK;

  // Reference model state
  logic [W-1:0] mq [NCH][$];
  logic [W-1:0] outq [$];
  logic [1:0]   m_mode;
  int           m_drop;

  // Currently driven strobes
  logic         cur_we, cur_re;
  logic [3:0]   cur_wa, cur_ra;
  logic [W-1:0] cur_wd;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    outq.delete();
    m_mode = 2'd0;
    m_drop = 0;
  endfunction

  function automatic void model_step(input logic we, input logic [3:0] wa, input logic [W-1:0] wd,
                                     input logic re, input logic [3:0] ra);
    bit fire, full_before;
    logic [W-1:0] o, a, x, r;
    if (we && wa == 4'd13) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      outq.delete();
      m_drop = 0;
      return;
    end
    fire = (outq.size() < OUT_DEPTH);
    for (int i = 0; i < NCH; i++) if (mq[i].size() == 0) fire = 0;
    r = '0;
    if (fire) begin
      o = '0; a = '1; x = '0;
      for (int i = 0; i < NCH; i++) begin
        o = o | mq[i][0]; a = a & mq[i][0]; x = x ^ mq[i][0];
      end
      case (m_mode)
        2'd0: r = o;
        2'd1: r = a;
        2'd2: r = x;
        default: r = mq[0][0];
      endcase
    end
    full_before = 0;
    if (we && int'(wa) < NCH) full_before = (mq[int'(wa)].size() == IN_DEPTH);
    if (re && ra == 4'd9 && outq.size() > 0) void'(outq.pop_front());
    if (fire) begin
      for (int i = 0; i < NCH; i++) void'(mq[i].pop_front());
      outq.push_back(r);
    end
    if (we && int'(wa) < NCH) begin
      if (full_before) begin
        if (m_drop < 255) m_drop++;
      end else mq[int'(wa)].push_back(wd);
    end
    if (we && wa == 4'd12) m_mode = wd[1:0];
  endfunction

  function automatic logic [W-1:0] exp_read(input logic [3:0] addr);
    if (int'(addr) < NCH) return (mq[int'(addr)].size() < IN_DEPTH) ? W'(1) : '0;
    case (addr)
      4'd8:    return (outq.size() != 0) ? W'(1) : '0;
      4'd9:    return (outq.size() != 0) ? outq[0] : '0;
      4'd10:   return W'(m_mode);
      4'd11:   return W'(m_drop);
      4'd12:   return W'(outq.size());
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic we, input logic [3:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [3:0] ra);
    cur_we = we; cur_wa = wa; cur_wd = wd; cur_re = re; cur_ra = ra;
    bus.write_en = we; bus.write_address = wa; bus.write_data = wd;
    bus.read_en = re; bus.read_address = ra;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(cur_we, cur_wa, cur_wd, cur_re, cur_ra);
    #1;
    cur_we = 1'b0; cur_re = 1'b0;
    bus.write_en = 1'b0; bus.read_en = 1'b0;
  endtask

  task automatic cyc(input logic we, input logic [3:0] wa, input logic [W-1:0] wd,
                     input logic re, input logic [3:0] ra);
    drive(we, wa, wd, re, ra);
    tick();
  endtask

  task automatic look(input logic [3:0] addr);
    bus.read_en = 1'b0; cur_re = 1'b0;
    bus.read_address = addr; cur_ra = addr;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    for (int k = 0; k < 2; k++) begin
      look(4'd0);  vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL rst_nf0 got=%h exp=%h", bus.read_data, W'(1)); end
      look(4'd1);  vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL rst_nf1 got=%h exp=%h", bus.read_data, W'(1)); end
      look(4'd8);  vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL rst_ne got=%h exp=0", bus.read_data); end
      look(4'd12); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL rst_occ got=%h exp=0", bus.read_data); end
      look(4'd10); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL rst_mode got=%h exp=0", bus.read_data); end
      look(4'd11); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL rst_drop got=%h exp=0", bus.read_data); end
      vectors++; if (bus.write_rdy !== 1'b1 || bus.read_rdy !== 1'b1) begin miscompares++; $display("FAIL rdy got=%b%b exp=11", bus.write_rdy, bus.read_rdy); end
      if (k == 0) begin
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        #1;
      end
    end
  endtask

  task automatic test_basic();
    cyc(1, 4'd0, 8'h0F, 0, 4'd0);
    cyc(1, 4'd1, 8'hF0, 0, 4'd0);
    look(4'd8); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL basic_early got=%h exp=0", bus.read_data); end
    cyc(0, 4'd0, '0, 0, 4'd0);
    look(4'd8); vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL basic_ne got=%h exp=1", bus.read_data); end
    look(4'd9); vectors++; if (bus.read_data !== 8'hFF || exp_read(4'd9) !== 8'hFF) begin miscompares++; $display("FAIL basic_or got=%h exp=ff", bus.read_data); end
    drive(0, 4'd0, '0, 1, 4'd9);
    vectors++; if (bus.read_data !== 8'hFF) begin miscompares++; $display("FAIL basic_prepop got=%h exp=ff", bus.read_data); end
    tick();
    look(4'd8); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL basic_empty got=%h exp=0", bus.read_data); end
  endtask

  task automatic test_modes();
    cyc(1, 4'd12, 8'h02, 0, 4'd0);
    cyc(1, 4'd0, 8'hAA, 0, 4'd0);
    cyc(1, 4'd1, 8'hFF, 0, 4'd0);
    cyc(0, 4'd0, '0, 0, 4'd0);
    look(4'd9); vectors++; if (bus.read_data !== 8'h55) begin miscompares++; $display("FAIL mode_xor got=%h exp=55", bus.read_data); end
    cyc(0, 4'd0, '0, 1, 4'd9);
    cyc(1, 4'd12, 8'h01, 0, 4'd0);
    cyc(1, 4'd0, 8'hAA, 0, 4'd0);
    cyc(1, 4'd1, 8'h0F, 0, 4'd0);
    cyc(0, 4'd0, '0, 0, 4'd0);
    look(4'd9); vectors++; if (bus.read_data !== 8'h0A) begin miscompares++; $display("FAIL mode_and got=%h exp=0a", bus.read_data); end
    look(4'd10); vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL mode_rd got=%h exp=1", bus.read_data); end
    cyc(0, 4'd0, '0, 1, 4'd9);
  endtask

  task automatic test_drop();
    for (int k = 0; k < 5; k++) cyc(1, 4'd0, W'($urandom), 0, 4'd0);
    look(4'd0);  vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL drop_full got=%h exp=0", bus.read_data); end
    look(4'd11); vectors++; if (bus.read_data !== W'(3)) begin miscompares++; $display("FAIL drop_cnt got=%h exp=3", bus.read_data); end
    for (int k = 0; k < 300; k++) cyc(1, 4'd0, W'($urandom), 0, 4'd0);
    look(4'd11); vectors++; if (bus.read_data !== W'(255) || exp_read(4'd11) !== W'(255)) begin miscompares++; $display("FAIL drop_sat got=%h exp=ff", bus.read_data); end
    cyc(1, 4'd13, '0, 0, 4'd0);
    look(4'd11); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL drop_clr got=%h exp=0", bus.read_data); end
  endtask

  task automatic test_out_full();
    logic [W-1:0] d0 [6];
    logic [W-1:0] d1 [6];
    cyc(1, 4'd12, 8'h00, 0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      d0[k] = W'($urandom); d1[k] = W'($urandom);
      cyc(1, 4'd0, d0[k], 0, 4'd0);
      cyc(1, 4'd1, d1[k], 0, 4'd0);
    end
    cyc(0, 4'd0, '0, 0, 4'd0);
    look(4'd12); vectors++; if (bus.read_data !== W'(OUT_DEPTH)) begin miscompares++; $display("FAIL full_occ got=%h exp=%h", bus.read_data, W'(OUT_DEPTH)); end
    look(4'd0);  vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL full_in0 got=%h exp=0", bus.read_data); end
    look(4'd1);  vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL full_in1 got=%h exp=0", bus.read_data); end
    look(4'd11); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL full_nodrop got=%h exp=0", bus.read_data); end
    for (int n = 0; n < 6; n++) begin
      drive(0, 4'd0, '0, 1, 4'd9);
      vectors++; if (bus.read_data !== (d0[n] | d1[n])) begin miscompares++; $display("FAIL drain_%0d got=%h exp=%h", n, bus.read_data, d0[n] | d1[n]); end
      tick();
    end
    look(4'd12); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL drain_occ got=%h exp=0", bus.read_data); end
    look(4'd8);  vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL drain_ne got=%h exp=0", bus.read_data); end
  endtask

  task automatic test_clear();
    cyc(1, 4'd12, 8'h03, 0, 4'd0);
    cyc(1, 4'd0, W'($urandom), 0, 4'd0);
    cyc(1, 4'd1, W'($urandom), 0, 4'd0);
    for (int k = 0; k < 3; k++) cyc(1, 4'd0, W'($urandom), 0, 4'd0);
    look(4'd11); vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL clr_pre_drop got=%h exp=1", bus.read_data); end
    drive(1, 4'd13, W'($urandom), 1, 4'd9);
    vectors++; if (bus.read_data !== exp_read(4'd9) || exp_read(4'd12) == '0) begin miscompares++; $display("FAIL clr_head got=%h exp=%h", bus.read_data, exp_read(4'd9)); end
    tick();
    look(4'd12); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL clr_occ got=%h exp=0", bus.read_data); end
    look(4'd8);  vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL clr_ne got=%h exp=0", bus.read_data); end
    look(4'd0);  vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL clr_nf0 got=%h exp=1", bus.read_data); end
    look(4'd1);  vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL clr_nf1 got=%h exp=1", bus.read_data); end
    look(4'd11); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL clr_drop got=%h exp=0", bus.read_data); end
    look(4'd10); vectors++; if (bus.read_data !== W'(3)) begin miscompares++; $display("FAIL clr_mode got=%h exp=3", bus.read_data); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 4'd12, 8'h01, 0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 4'd0, W'($urandom), 0, 4'd0);
      cyc(1, 4'd1, W'($urandom), 0, 4'd0);
    end
    cyc(0, 4'd0, '0, 0, 4'd0);
    look(4'd12); vectors++; if (bus.read_data !== W'(3)) begin miscompares++; $display("FAIL mid_pre got=%h exp=3", bus.read_data); end
    RST = 1'b1;
    model_reset();
    look(4'd12); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL mid_occ got=%h exp=0", bus.read_data); end
    bus.write_en = 1'b1; bus.write_address = 4'd0; bus.write_data = 8'h77;
    bus.read_en = 1'b1; bus.read_address = 4'd9;
    @(posedge CLK); #1;
    bus.write_en = 1'b0; bus.read_en = 1'b0;
    RST = 1'b0;
    #1;
    look(4'd10); vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL mid_mode got=%h exp=0", bus.read_data); end
    look(4'd9);  vectors++; if (bus.read_data !== '0) begin miscompares++; $display("FAIL mid_stale got=%h exp=0", bus.read_data); end
    look(4'd0);  vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL mid_nf0 got=%h exp=1", bus.read_data); end
    cyc(1, 4'd0, 8'hA0, 0, 4'd0);
    cyc(1, 4'd1, 8'h0F, 0, 4'd0);
    cyc(0, 4'd0, '0, 0, 4'd0);
    look(4'd12); vectors++; if (bus.read_data !== W'(1)) begin miscompares++; $display("FAIL mid_new_occ got=%h exp=1", bus.read_data); end
    look(4'd9);  vectors++; if (bus.read_data !== 8'hAF) begin miscompares++; $display("FAIL mid_new got=%h exp=af", bus.read_data); end
  endtask

  task automatic test_random();
    logic we, re;
    logic [3:0] wa, ra, la;
    logic [W-1:0] wd;
    int r;
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 99));
      we = (r < 70);
      wa = (r < 60) ? 4'($urandom_range(0, 3)) : (r < 68) ? 4'd12 : (r < 69) ? 4'd13 : 4'($urandom_range(0, 15));
      wd = W'($urandom);
      re = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 2) != 0) ? 4'd9 : 4'($urandom_range(0, 15));
      drive(we, wa, wd, re, ra);
      vectors++; if (bus.read_data !== exp_read(ra)) begin miscompares++; $display("FAIL rnd_pre n=%0d addr=%0d got=%h exp=%h", n, ra, bus.read_data, exp_read(ra)); end
      tick();
      la = 4'($urandom_range(0, 15));
      look(la);
      vectors++; if (bus.read_data !== exp_read(la)) begin miscompares++; $display("FAIL rnd_post n=%0d addr=%0d got=%h exp=%h", n, la, bus.read_data, exp_read(la)); end
    end
  endtask

  initial begin
    cur_we = 1'b0; cur_re = 1'b0; cur_wa = '0; cur_ra = '0; cur_wd = '0;
    bus.write_en = 1'b0; bus.write_address = '0; bus.write_data = '0;
    bus.read_en = 1'b0; bus.read_address = '0;
    #1;
    test_reset();
    test_basic();
    test_modes();
    test_drop();
    test_out_full();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
